mux_arbiter: RTL

//  Packet-level switch allocator that sits directly upstream of the 2:1 router output mux and drives its one-hot sel.

---
 rtl/mux_arbiter_if.sv | 43 ++++
 rtl/mux_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_arbiter_if
//   Bundles the flit-side and credit-side signals of the 2:1 switch allocator.
//   slave  : the allocator (consumes valids/types/credits, drives sel/grants)
//   master : the surrounding router / bench (drives valids/types/credits)
// Signals
//   ivalid_0/1   flit valid per input port
//   itype_0/1    flit type field per input port (HEAD/DATA/TAIL/NONE)
//   icredit      one-cycle pulse, one downstream buffer slot freed
//   sel          one-hot mux select (01 = port 0, 10 = port 1, 00 = none)
//   grant_0/1    flit on that port transferred this cycle
//   oen          output flit valid to downstream
//   ocredit_err  sticky credit overflow flag
// -----------------------------------------------------------------------------
`ifndef TYPE_HEAD
`define TYPE_NONE 2'b00
`define TYPE_HEAD 2'b01
`define TYPE_DATA 2'b10
`define TYPE_TAIL 2'b11
`endif

interface mux_arbiter_if;
  logic       ivalid_0;
  logic [1:0] itype_0;
  logic       ivalid_1;
  logic [1:0] itype_1;
  logic       icredit;
  logic [1:0] sel;
  logic       grant_0;
  logic       grant_1;
  logic       oen;
  logic       ocredit_err;

  modport slave (
    input  ivalid_0, itype_0, ivalid_1, itype_1, icredit,
    output sel, grant_0, grant_1, oen, ocredit_err
  );

  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, icredit,
    input  sel, grant_0, grant_1, oen, ocredit_err
  );
endinterface

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//   Packet-level switch allocator in front of a 2:1 router output mux.
//   A HEAD flit on either port wins the output (round-robin on ties) and the
//   winner keeps the output until its TAIL flit has been transferred. Flits
//   are only forwarded while the downstream credit counter is non-zero.
// Ports
//   clk    router clock, all state on the rising edge
//   rst_   asynchronous active-low reset
//   bus    mux_arbiter_if.slave (valids, types, credit pulse in;
//          sel, grants, oen, ocredit_err out)
// Parameters
//   CREDITS  downstream buffer depth in flits (credit counter reset value)
//   CNTW     credit counter width, 2**CNTW > CREDITS
// -----------------------------------------------------------------------------
`ifndef TYPE_HEAD
`define TYPE_NONE 2'b00
`define TYPE_HEAD 2'b01
`define TYPE_DATA 2'b10
`define TYPE_TAIL 2'b11
`endif

module mux_arbiter #(
  parameter int CREDITS = 4,
  parameter int CNTW    = 3
) (
  input  logic         clk,
  input  logic         rst_,
  mux_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_0, BUSY_1} state_t;

  localparam logic [CNTW-1:0] CRED_MAX = CNTW'(CREDITS);
  localparam logic [CNTW-1:0] CRED_ONE = CNTW'(1);

  state_t          state;
  state_t          next_state;
  logic [CNTW-1:0] credit_cnt;
  logic            rr_ptr;
  logic            credit_err;
  logic [1:0]      sel_q;

  logic            req_0;
  logic            req_1;
  logic            grant_0;
  logic            grant_1;
  logic            xfer;
  logic            tail_0;
  logic            tail_1;

  assign req_0   = bus.ivalid_0 && (bus.itype_0 == `TYPE_HEAD);
  assign req_1   = bus.ivalid_1 && (bus.itype_1 == `TYPE_HEAD);

  // Grants depend only on registered state/count plus the holding port's valid,
  // so a stalled port (no credit) simply keeps presenting its flit.
  assign grant_0 = (state == BUSY_0) && bus.ivalid_0 && (credit_cnt != '0);
  assign grant_1 = (state == BUSY_1) && bus.ivalid_1 && (credit_cnt != '0);
  assign xfer    = grant_0 || grant_1;
  assign tail_0  = grant_0 && (bus.itype_0 == `TYPE_TAIL);
  assign tail_1  = grant_1 && (bus.itype_1 == `TYPE_TAIL);

  assign bus.grant_0     = grant_0;
  assign bus.grant_1     = grant_1;
  assign bus.oen         = xfer;
  assign bus.sel         = sel_q;
  assign bus.ocredit_err = credit_err;

  // Next-state: arbitration in IDLE, lock release on TAIL transfer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_0 && req_1)
          next_state = rr_ptr ? BUSY_1 : BUSY_0;
        else if (req_0)
          next_state = BUSY_0;
        else if (req_1)
          next_state = BUSY_1;
      end
      BUSY_0: if (tail_0) next_state = IDLE;
      BUSY_1: if (tail_1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, select register and round-robin pointer. sel is loaded from the
  // next state so it is a clean flop output aligned with the state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= IDLE;
      sel_q  <= 2'b00;
      rr_ptr <= 1'b0;
    end else begin
      state <= next_state;
      case (next_state)
        BUSY_0:  sel_q <= 2'b01;
        BUSY_1:  sel_q <= 2'b10;
        default: sel_q <= 2'b00;
      endcase
      if (tail_0)
        rr_ptr <= 1'b1;
      else if (tail_1)
        rr_ptr <= 1'b0;
    end
  end

  // Credit counter: a transfer and a returned credit in the same cycle cancel.
  // A credit returned while already full is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      if (xfer && !bus.icredit) begin
        credit_cnt <= credit_cnt - CRED_ONE;
      end else if (!xfer && bus.icredit) begin
        if (credit_cnt == CRED_MAX)
          credit_err <= 1'b1;
        else
          credit_cnt <= credit_cnt + CRED_ONE;
      end
    end
  end

endmodule
